// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch requester, data requester and shared memory port.
// The master modport is the arbiter's view; slave is the view of the surrounding requesters/memory.
interface mem_arbiter_if;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        o_if_gnt;
   logic        o_if_rvalid;
   logic [31:0] o_if_rdata;

   logic        i_dm_req;
   logic        i_dm_we;
   logic [31:0] i_dm_addr;
   logic [31:0] i_dm_wdata;
   logic [3:0]  i_dm_be;
   logic        o_dm_gnt;
   logic        o_dm_rvalid;
   logic [31:0] o_dm_rdata;

   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_be;
   logic        i_mem_gnt;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;

   modport master (
      input  i_if_req, i_if_addr,
      output o_if_gnt, o_if_rvalid, o_if_rdata,
      input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
      output o_dm_gnt, o_dm_rvalid, o_dm_rdata,
      output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
      input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
   );

   modport slave (
      output i_if_req, i_if_addr,
      input  o_if_gnt, o_if_rvalid, o_if_rdata,
      output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
      input  o_dm_gnt, o_dm_rvalid, o_dm_rdata,
      input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
      output i_mem_gnt, i_mem_rvalid, i_mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory port, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin selection; otherwise data has fixed priority.
module mem_arbiter (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   mem_arbiter_if.master        bus,
   output logic                 o_busy,
   output logic                 o_proto_err
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      RSP  = 2'b10
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_ownerData;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_protoErr;
   logic        w_anyReq;
   logic        w_pickData;

   assign w_anyReq = bus.i_if_req | bus.i_dm_req;

`ifdef MEM_ARB_RR_EN
   logic r_lastData;

   // On a tie the requester that was not granted most recently wins.
   assign w_pickData = bus.i_dm_req & (~bus.i_if_req | ~r_lastData);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lastData <= 1'b0;
      end else if (r_state == REQ && bus.i_mem_gnt) begin
         r_lastData <= r_ownerData;
      end
   end
`else
   assign w_pickData = bus.i_dm_req;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Owner and request fields are frozen at selection so REQ drives memory purely from registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ownerData <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= 32'h0;
         r_wdata     <= 32'h0;
         r_be        <= 4'h0;
      end else if (r_state == IDLE && w_anyReq) begin
         r_ownerData <= w_pickData;
         r_we        <= w_pickData ? bus.i_dm_we    : 1'b0;
         r_addr      <= w_pickData ? bus.i_dm_addr  : bus.i_if_addr;
         r_wdata     <= w_pickData ? bus.i_dm_wdata : 32'h0;
         r_be        <= w_pickData ? bus.i_dm_be    : 4'hF;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_protoErr <= 1'b0;
      end else if (bus.i_mem_rvalid && r_state != RSP) begin
         r_protoErr <= 1'b1;
      end
   end

   always_comb begin
      w_next          = r_state;
      bus.o_mem_req   = 1'b0;
      bus.o_if_gnt    = 1'b0;
      bus.o_dm_gnt    = 1'b0;
      bus.o_if_rvalid = 1'b0;
      bus.o_dm_rvalid = 1'b0;
      bus.o_if_rdata  = 32'h0;
      bus.o_dm_rdata  = 32'h0;
      unique case (r_state)
         IDLE: begin
            if (w_anyReq) w_next = REQ;
         end
         REQ: begin
            bus.o_mem_req = 1'b1;
            if (bus.i_mem_gnt) begin
               bus.o_if_gnt = ~r_ownerData;
               bus.o_dm_gnt = r_ownerData;
               w_next       = RSP;
            end
         end
         RSP: begin
            if (bus.i_mem_rvalid) begin
               bus.o_if_rvalid = ~r_ownerData;
               bus.o_dm_rvalid = r_ownerData;
               bus.o_if_rdata  = r_ownerData ? 32'h0 : bus.i_mem_rdata;
               bus.o_dm_rdata  = r_ownerData ? bus.i_mem_rdata : 32'h0;
               w_next          = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign bus.o_mem_we    = r_we;
   assign bus.o_mem_addr  = r_addr;
   assign bus.o_mem_wdata = r_wdata;
   assign bus.o_mem_be    = r_be;
   assign o_busy          = (r_state != IDLE);
   assign o_proto_err     = r_protoErr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expected transactions are queued in a scoreboard
// and retired as the bench plays the memory and sees requester responses.
module tb_mem_arbiter;

   typedef struct {
      logic        isData;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
   } txn_t;

   logic clock = 1'b0;
   logic rstN;
   logic busy;
   logic protoErr;
   int   testsRun    = 0;
   int   testsFailed = 0;
   int   cycleCount  = 0;
   txn_t sb[$];

   mem_arbiter_if bus();

   mem_arbiter dut (
      .i_clk       (clock),
      .i_rst_n     (rstN),
      .bus         (bus),
      .o_busy      (busy),
      .o_proto_err (protoErr)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycleCount <= cycleCount + 1;

   // Hard stop in case a bounded wait logic error still lets the run wander.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic isData, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
      if (isData) begin
         bus.i_dm_req   = 1'b1;
         bus.i_dm_we    = we;
         bus.i_dm_addr  = addr;
         bus.i_dm_wdata = wdata;
         bus.i_dm_be    = be;
      end else begin
         bus.i_if_req  = 1'b1;
         bus.i_if_addr = addr;
      end
   endtask

   task automatic pushExp(input logic isData, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] rdata);
      txn_t e;
      e.isData = isData;
      e.we     = we;
      e.addr   = addr;
      e.wdata  = wdata;
      e.be     = be;
      e.rdata  = rdata;
      sb.push_back(e);
   endtask

   // Acts as the memory for one transaction: optional grant stall, optional response delay.
   task automatic memServe(input int gntDelay, input int rspDelay, input logic [1:0] dropMask,
                           output int waited, output int gntCycle);
      txn_t e;
      waited   = 0;
      gntCycle = 0;
      while (!bus.o_mem_req && waited < 20) begin
         step();
         waited++;
      end
      checkOutput("mem_req_seen", bus.o_mem_req, 32'd1);
      checkOutput("sb_has_entry", (sb.size() > 0), 32'd1);
      if (!bus.o_mem_req || sb.size() == 0) return;
      e = sb[0];
      for (int i = 0; i < gntDelay; i++) begin
         checkOutput("stall_req",   bus.o_mem_req,   32'd1);
         checkOutput("stall_addr",  bus.o_mem_addr,  e.addr);
         checkOutput("stall_wdata", bus.o_mem_wdata, e.wdata);
         checkOutput("stall_be",    bus.o_mem_be,    32'(e.be));
         checkOutput("stall_gnts",  {bus.o_if_gnt, bus.o_dm_gnt}, 32'd0);
         step();
      end
      bus.i_mem_gnt = 1'b1;
      #1;
      gntCycle = cycleCount;
      checkOutput("gnt_we",    bus.o_mem_we,    32'(e.we));
      checkOutput("gnt_addr",  bus.o_mem_addr,  e.addr);
      checkOutput("gnt_wdata", bus.o_mem_wdata, e.wdata);
      checkOutput("gnt_be",    bus.o_mem_be,    32'(e.be));
      checkOutput("if_gnt",    bus.o_if_gnt,    32'(!e.isData));
      checkOutput("dm_gnt",    bus.o_dm_gnt,    32'(e.isData));
      if (dropMask[0]) bus.i_if_req = 1'b0;
      if (dropMask[1]) bus.i_dm_req = 1'b0;
      step();
      bus.i_mem_gnt = 1'b0;
      #1;
      checkOutput("gnt_single_pulse", {bus.o_if_gnt, bus.o_dm_gnt}, 32'd0);
      checkOutput("busy_rsp", busy, 32'd1);
      for (int i = 0; i < rspDelay; i++) begin
         checkOutput("rvalid_early", {bus.o_if_rvalid, bus.o_dm_rvalid}, 32'd0);
         step();
      end
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = e.rdata;
      #1;
      checkOutput("if_rvalid", bus.o_if_rvalid, 32'(!e.isData));
      checkOutput("dm_rvalid", bus.o_dm_rvalid, 32'(e.isData));
      checkOutput("owner_rdata", e.isData ? bus.o_dm_rdata : bus.o_if_rdata, e.rdata);
      checkOutput("other_rdata", e.isData ? bus.o_if_rdata : bus.o_dm_rdata, 32'h0);
      void'(sb.pop_front());
      step();
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_rdata  = 32'h0;
      #1;
      checkOutput("busy_bubble", busy, 32'd0);
      checkOutput("rvalid_single_pulse", {bus.o_if_rvalid, bus.o_dm_rvalid}, 32'd0);
   endtask

   initial begin
      int waited;
      int g0;
      int g1;
      int g2;

      bus.i_if_req     = 1'b0;
      bus.i_if_addr    = 32'h0;
      bus.i_dm_req     = 1'b0;
      bus.i_dm_we      = 1'b0;
      bus.i_dm_addr    = 32'h0;
      bus.i_dm_wdata   = 32'h0;
      bus.i_dm_be      = 4'h0;
      bus.i_mem_gnt    = 1'b0;
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_rdata  = 32'h0;
      rstN             = 1'b0;
      #1;
      checkOutput("rst_busy",     busy,             32'd0);
      checkOutput("rst_err",      protoErr,         32'd0);
      checkOutput("rst_mem_req",  bus.o_mem_req,    32'd0);
      checkOutput("rst_mem_addr", bus.o_mem_addr,   32'h0);
      checkOutput("rst_mem_be",   bus.o_mem_be,     32'h0);
      checkOutput("rst_gnts",     {bus.o_if_gnt, bus.o_dm_gnt}, 32'd0);
      step();
      step();
      rstN = 1'b1;
      step();

      // Grant with nothing outstanding must be ignored.
      bus.i_mem_gnt = 1'b1;
      #1;
      checkOutput("idle_gnt_ignored", {bus.o_if_gnt, bus.o_dm_gnt}, 32'd0);
      step();
      checkOutput("idle_gnt_busy", busy, 32'd0);
      bus.i_mem_gnt = 1'b0;

      // Single fetch with immediate grant and next-cycle response.
      applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
      pushExp(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF);
      memServe(0, 0, 2'b01, waited, g0);
      checkOutput("single_fetch_latency", waited, 32'd1);

      // Simultaneous fetch and store.
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      applyStimulus(1'b1, 1'b1, 32'h200, 32'h55, 4'hF);
`ifdef MEM_ARB_RR_EN
      pushExp(1'b1, 1'b1, 32'h200, 32'h55, 4'hF, 32'hA0000001);
      pushExp(1'b0, 1'b0, 32'h0,   32'h0,  4'hF, 32'hA0000002);
      pushExp(1'b1, 1'b1, 32'h200, 32'h55, 4'hF, 32'hA0000003);
      pushExp(1'b0, 1'b0, 32'h0,   32'h0,  4'hF, 32'hA0000004);
      memServe(0, 0, 2'b00, waited, g0);
      memServe(0, 0, 2'b00, waited, g0);
      memServe(0, 0, 2'b00, waited, g0);
      memServe(0, 0, 2'b11, waited, g0);
`else
      pushExp(1'b1, 1'b1, 32'h200, 32'h55, 4'hF, 32'hA0000001);
      pushExp(1'b0, 1'b0, 32'h0,   32'h0,  4'hF, 32'hA0000002);
      memServe(0, 0, 2'b10, waited, g0);
      memServe(0, 0, 2'b01, waited, g0);
`endif
      checkOutput("tie_sb_drained", sb.size(), 32'd0);

      // Memory stall: fetch owner persists although fetch drops and data requests meanwhile.
      applyStimulus(1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
      pushExp(1'b0, 1'b0, 32'h300, 32'h0, 4'hF, 32'hCAFE0001);
      step();
      bus.i_if_req = 1'b0;
      applyStimulus(1'b1, 1'b1, 32'h600, 32'h77, 4'h3);
      pushExp(1'b1, 1'b1, 32'h600, 32'h77, 4'h3, 32'h11112222);
      memServe(5, 0, 2'b00, waited, g0);
      memServe(0, 0, 2'b10, waited, g0);

      // Back-to-back loads with one idle response cycle each.
      applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
      pushExp(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 32'h000000A1);
      pushExp(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 32'h000000A2);
      pushExp(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 32'h000000A3);
      memServe(0, 1, 2'b00, waited, g0);
      memServe(0, 1, 2'b00, waited, g1);
      checkOutput("b2b_bubble_1", waited, 32'd1);
      memServe(0, 1, 2'b10, waited, g2);
      checkOutput("b2b_bubble_2", waited, 32'd1);
      checkOutput("b2b_spacing_1", g1 - g0, 32'd4);
      checkOutput("b2b_spacing_2", g2 - g1, 32'd4);

      // Response while still in REQ is a protocol error and is not routed.
      applyStimulus(1'b0, 1'b0, 32'h700, 32'h0, 4'h0);
      pushExp(1'b0, 1'b0, 32'h700, 32'h0, 4'hF, 32'hBEEF0007);
      step();
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = 32'h99;
      #1;
      checkOutput("req_rvalid_not_routed", {bus.o_if_rvalid, bus.o_dm_rvalid}, 32'd0);
      checkOutput("req_rvalid_rdata_zero", bus.o_if_rdata, 32'h0);
      step();
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_rdata  = 32'h0;
      #1;
      checkOutput("proto_err_set", protoErr, 32'd1);
      memServe(0, 0, 2'b01, waited, g0);
      checkOutput("proto_err_sticky", protoErr, 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("proto_err_cleared", protoErr, 32'd0);
      step();
      rstN = 1'b1;
      step();

      // Reset while waiting for the response abandons the transaction.
      applyStimulus(1'b0, 1'b0, 32'h500, 32'h0, 4'h0);
      step();
      bus.i_mem_gnt = 1'b1;
      #1;
      checkOutput("abandon_gnt", bus.o_if_gnt, 32'd1);
      step();
      bus.i_mem_gnt = 1'b0;
      bus.i_if_req  = 1'b0;
      #1;
      checkOutput("abandon_busy_rsp", busy, 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("abandon_busy",    busy,           32'd0);
      checkOutput("abandon_mem_req", bus.o_mem_req,  32'd0);
      checkOutput("abandon_addr",    bus.o_mem_addr, 32'h0);
      checkOutput("abandon_be",      bus.o_mem_be,   32'h0);
      checkOutput("abandon_err",     protoErr,       32'd0);
      step();
      rstN = 1'b1;
      step();
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = 32'h1234;
      #1;
      checkOutput("late_rvalid_blocked", {bus.o_if_rvalid, bus.o_dm_rvalid}, 32'd0);
      checkOutput("late_rdata_zero", bus.o_if_rdata | bus.o_dm_rdata, 32'h0);
      step();
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_rdata  = 32'h0;
      #1;
      checkOutput("late_rvalid_err", protoErr, 32'd1);
      checkOutput("late_rvalid_idle", busy, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
